// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-unit write-back scheduler.
package rf_wb_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned NREG   = 2 ** REG_AW;

  typedef logic [REG_AW-1:0] reg_idx_t;
  typedef logic [NREG-1:0]   busy_vec_t;

  // One write-back request as presented by a requester.
  typedef struct packed {
    logic            valid;
    reg_idx_t        rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. req[0]/gnt[0] is requester A, req[1]/gnt[1] is B.
// The pointer remembers the last granted requester; after reset A has priority.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       onehot0
);

  logic prio_b_q, prio_b_d;

  // Pointer register: 1 means B wins the next contended cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_b_q <= 1'b0;
    end else begin
      prio_b_q <= prio_b_d;
    end
  end

  // Next pointer: the requester not granted this cycle gets priority next.
  always_comb begin
    prio_b_d = prio_b_q;
    if (gnt[0]) begin
      prio_b_d = 1'b1;
    end else if (gnt[1]) begin
      prio_b_d = 1'b0;
    end
  end

  // Grant: a lone requester always wins; on contention the pointer decides.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = prio_b_q ? 2'b10 : 2'b01;
    end
    onehot0 = ~(gnt[0] & gnt[1]);
  end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Write-back scheduler and scoreboard for the 32x32 register unit.
// Requester A (ALU/EX) and B (load/mul) share the single write port through a
// round-robin arbiter; a busy bit per register stalls decode on RAW/WAW hazards.
// Optional macro RF_WB_PERF_EN adds stall / contention performance counters.
module rf_wb_scheduler
  import rf_wb_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_valid,
  input  reg_idx_t        iss_rs1,
  input  reg_idx_t        iss_rs2,
  input  reg_idx_t        iss_rd,
  input  logic            iss_rd_en,
  output logic            iss_stall,
  input  logic            wa_valid,
  input  reg_idx_t        wa_rd,
  input  logic [XLEN-1:0] wa_data,
  output logic            wa_ready,
  input  logic            wb_valid,
  input  reg_idx_t        wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            wb_ready,
  output logic            rf_we,
  output reg_idx_t        rf_rd,
  output logic [XLEN-1:0] rf_wdata,
`ifdef RF_WB_PERF_EN
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_conflict_cnt,
`endif
  output busy_vec_t       busy_vec
);

  busy_vec_t       busy_q, busy_d;
  logic            we_q, we_d;
  reg_idx_t        rd_q, rd_d;
  logic [XLEN-1:0] wd_q, wd_d;

  wb_req_t    req_a, req_b, win;
  logic [1:0] gnt;
  logic       gnt_ok;
  logic       xfer;
  logic       accept;

  assign req_a = '{valid: wa_valid, rd: wa_rd, data: wa_data};
  assign req_b = '{valid: wb_valid, rd: wb_rd, data: wb_data};

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({wb_valid, wa_valid}),
    .gnt     (gnt),
    .onehot0 (gnt_ok)
  );

  // Hazard check against registered busy bits only; x0 never participates.
  always_comb begin
    iss_stall = iss_valid &
                ((busy_q[iss_rs1] & (iss_rs1 != '0)) |
                 (busy_q[iss_rs2] & (iss_rs2 != '0)) |
                 (iss_rd_en & (iss_rd != '0) & busy_q[iss_rd]));
    accept    = iss_valid & ~iss_stall;
  end

  // Grant steering: pick the winning request and flag the transfer.
  always_comb begin
    wa_ready = gnt[0];
    wb_ready = gnt[1];
    win      = gnt[1] ? req_b : req_a;
    xfer     = (|gnt) & gnt_ok & win.valid;
  end

  // Next-state for the write port and scoreboard; set is applied after clear so
  // a fresh issue to a register being written (non-busy) stays pending.
  always_comb begin
    we_d   = xfer & (win.rd != '0);
    rd_d   = rd_q;
    wd_d   = wd_q;
    busy_d = busy_q;
    if (we_d) begin
      rd_d           = win.rd;
      wd_d           = win.data;
      busy_d[win.rd] = 1'b0;
    end
    if (accept && iss_rd_en && (iss_rd != '0)) begin
      busy_d[iss_rd] = 1'b1;
    end
  end

  // Write-port and scoreboard registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      rd_q   <= '0;
      wd_q   <= '0;
      busy_q <= '0;
    end else begin
      we_q   <= we_d;
      rd_q   <= rd_d;
      wd_q   <= wd_d;
      busy_q <= busy_d;
    end
  end

  assign rf_we    = we_q;
  assign rf_rd    = rd_q;
  assign rf_wdata = wd_q;
  assign busy_vec = busy_q;

`ifdef RF_WB_PERF_EN
  logic [31:0] stall_cnt_q, conflict_cnt_q;

  // Free-running counters of stalled cycles and contended arbitration cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q    <= '0;
      conflict_cnt_q <= '0;
    end else begin
      if (iss_stall) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (wa_valid && wb_valid) begin
        conflict_cnt_q <= conflict_cnt_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt    = stall_cnt_q;
  assign perf_conflict_cnt = conflict_cnt_q;
`endif

endmodule
